// File: rtl/tmds_pkg.sv
// tmds_pkg: TMDS control tokens, alignment FSM states and decoded-word types
// shared by the channel decoder and any later multi-channel aligner.
package tmds_pkg;
    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} align_state_t;

    typedef logic [1:0] ctrl_t;

    typedef struct packed {
        logic       is_ctrl;
        ctrl_t      ctrl;
        logic [7:0] data;
    } word_t;

    function automatic logic [3:0] transitions(input logic [9:0] w);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 9; i++) n = n + 4'(w[i] ^ w[i+1]);
        return n;
    endfunction
endpackage

// File: rtl/tmds_decoder_if.sv
// tmds_decoder_if: raw word input and decoded outputs of one TMDS channel.
interface tmds_decoder_if;
    logic [9:0]     tmds_in;
    logic [7:0]     data_out;
    tmds_pkg::ctrl_t control_out;
    logic           ve_out;
    logic           valid_out;
    logic           locked_out;
    logic           err_out;

    modport master (
        output tmds_in,
        input  data_out, control_out, ve_out, valid_out, locked_out, err_out
    );
    modport slave (
        input  tmds_in,
        output data_out, control_out, ve_out, valid_out, locked_out, err_out
    );
endinterface

// File: rtl/tmds_word_decode.sv
// tmds_word_decode: combinational 10b->8b TMDS decode plus control-token match.
module tmds_word_decode
    import tmds_pkg::*;
(
    input  logic [9:0] word,
    output word_t      dec
);
    logic [7:0] d;
    logic [7:0] q;

    always_comb begin
        d    = word[9] ? ~word[7:0] : word[7:0];
        q    = '0;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = word[8] ? d[i] ^ d[i-1] : ~(d[i] ^ d[i-1]);
        dec.data    = q;
        dec.is_ctrl = word inside {CTRL_00, CTRL_01, CTRL_10, CTRL_11};
        dec.ctrl    = (word == CTRL_01) ? 2'd1 : (word == CTRL_10) ? 2'd2 : (word == CTRL_11) ? 2'd3 : 2'd0;
    end
endmodule

// File: rtl/tmds_decoder.sv
// tmds_decoder: TMDS receive channel decoder with control-token word alignment.
// Define TMDS_DECODER_ERR_EN to build the transition-count error flag.
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int LOCK_COUNT  = 16,
    parameter int DWELL_WORDS = 2048,
    parameter int MAX_GAP     = 4096
) (
    input logic           clk_in,
    input logic           rst_in,
    tmds_decoder_if.slave bus
);
    localparam int RW = $clog2(LOCK_COUNT + 1);
    localparam int DW = $clog2(DWELL_WORDS + 1);
    localparam int GW = $clog2(MAX_GAP + 1);

    align_state_t  state, state_n;
    logic [3:0]    offset, offset_n, offset_inc;
    logic [RW-1:0] run, run_n;
    logic [DW-1:0] dwell, dwell_n;
    logic [GW-1:0] gap, gap_n;
    logic [9:0]    prev, aligned;
    logic [19:0]   window;
    word_t         dec, s1_dec;
    logic          s1_locked;

    assign window     = {bus.tmds_in, prev};
    assign aligned    = window[offset +: 10];
    assign offset_inc = (offset == 4'd9) ? 4'd0 : offset + 4'd1;

    tmds_word_decode u_dec (.word(aligned), .dec(dec));

    always_comb begin
        state_n  = state;
        offset_n = offset;
        run_n    = run;
        dwell_n  = dwell;
        gap_n    = gap;
        case (state)
            SEARCH: begin
                if (dec.is_ctrl) begin
                    state_n = VERIFY;
                    run_n   = RW'(1);
                end
            end
            VERIFY: begin
                if (!dec.is_ctrl) begin
                    state_n = SEARCH;
                    run_n   = '0;
                end else if (run + RW'(1) == RW'(LOCK_COUNT)) begin
                    state_n = LOCKED;
                    run_n   = '0;
                end else begin
                    run_n = run + RW'(1);
                end
            end
            default: begin
                if (dec.is_ctrl) begin
                    gap_n = '0;
                end else if (gap + GW'(1) == GW'(MAX_GAP)) begin
                    state_n  = SEARCH;
                    offset_n = offset_inc;
                    gap_n    = '0;
                end else begin
                    gap_n = gap + GW'(1);
                end
            end
        endcase
        // Dwell expiry only applies while hunting; completing lock takes priority.
        if (state != LOCKED) begin
            if (state_n == LOCKED) begin
                dwell_n = '0;
            end else if (dwell + DW'(1) == DW'(DWELL_WORDS)) begin
                dwell_n  = '0;
                offset_n = offset_inc;
                state_n  = SEARCH;
                run_n    = '0;
            end else begin
                dwell_n = dwell + DW'(1);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state           <= SEARCH;
            offset          <= '0;
            run             <= '0;
            dwell           <= '0;
            gap             <= '0;
            prev            <= '0;
            s1_dec          <= '0;
            s1_locked       <= 1'b0;
            bus.data_out    <= '0;
            bus.control_out <= '0;
            bus.ve_out      <= 1'b0;
            bus.valid_out   <= 1'b0;
        end else begin
            state           <= state_n;
            offset          <= offset_n;
            run             <= run_n;
            dwell           <= dwell_n;
            gap             <= gap_n;
            prev            <= bus.tmds_in;
            s1_dec          <= dec;
            s1_locked       <= state == LOCKED;
            bus.data_out    <= s1_dec.is_ctrl ? 8'h00 : s1_dec.data;
            bus.control_out <= s1_dec.is_ctrl ? s1_dec.ctrl : bus.control_out;
            bus.ve_out      <= !s1_dec.is_ctrl;
            bus.valid_out   <= s1_locked;
        end
    end

    assign bus.locked_out = state == LOCKED;

`ifdef TMDS_DECODER_ERR_EN
    logic [3:0] s1_trans;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1_trans    <= '0;
            bus.err_out <= 1'b0;
        end else begin
            s1_trans    <= transitions(aligned);
            bus.err_out <= s1_locked && !s1_dec.is_ctrl && s1_trans >= 4'd7;
        end
    end
`else
    assign bus.err_out = 1'b0;
`endif
endmodule

// File: tb/tb_tmds_decoder.sv
// tb_tmds_decoder: randomized self-checking bench for tmds_decoder against
// a behavioural TMDS reference model.
`timescale 1ns/1ps
module tb_tmds_decoder;
    import tmds_pkg::*;

`ifdef TMDS_DECODER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] data;
        logic [1:0] ctrl;
        logic       ve;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    tmds_decoder_if bus();

    tmds_decoder #(.LOCK_COUNT(16), .DWELL_WORDS(32), .MAX_GAP(64)) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] tok_word(input int v);
        return (v == 0) ? 10'h354 : (v == 1) ? 10'h0AB : (v == 2) ? 10'h154 : 10'h2AB;
    endfunction

    function automatic int tok_val(input logic [9:0] w);
        for (int k = 0; k < 4; k++) if (w == tok_word(k)) return k;
        return -1;
    endfunction

    function automatic logic [7:0] ref_decode(input logic [9:0] w);
        int d, q, b;
        d = w[9] ? (~int'(w) & 255) : (int'(w) & 255);
        q = d & 1;
        for (int i = 1; i < 8; i++) begin
            b = ((d >> i) ^ (d >> (i - 1))) & 1;
            if (!w[8]) b = 1 - b;
            q = q + (b << i);
        end
        return 8'(q);
    endfunction

    function automatic int ref_trans(input logic [9:0] w);
        int n;
        n = 0;
        for (int i = 0; i < 9; i++) if (((int'(w) >> i) & 1) != ((int'(w) >> (i + 1)) & 1)) n++;
        return n;
    endfunction

    task automatic tick(input logic [9:0] w);
        @(posedge clk);
        #1;
        bus.tmds_in = w;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        bus.tmds_in = 10'h354;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        bus.tmds_in = 10'h000;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.tmds_in = 10'h354;
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if ({bus.data_out, bus.control_out, bus.ve_out, bus.valid_out, bus.locked_out, bus.err_out} !== 14'h0) begin
                errors++;
                $display("FAIL reset_outputs: got data=%h ctrl=%h ve=%b valid=%b locked=%b err=%b, expected all 0",
                         bus.data_out, bus.control_out, bus.ve_out, bus.valid_out, bus.locked_out, bus.err_out);
            end
        end
        rst = 1'b0;
        bus.tmds_in = 10'h000;
        for (int i = 0; i <= 16; i++) begin
            tick(10'h354);
            checks++;
            if (bus.locked_out !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_early_lock: iter %0d got locked=%b expected 0", i, bus.locked_out);
            end
        end
    endtask

    task automatic test_aligned_lock;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            tick(i == 16 ? 10'h1FF : 10'h354);
            if (i == 16 || i == 17) begin
                checks++;
                if (bus.locked_out !== (i == 17)) begin
                    errors++;
                    $display("FAIL aligned_lock_edge: iter %0d got locked=%b expected %b", i, bus.locked_out, i == 17);
                end
            end
            if (i == 18) begin
                checks++;
                if (bus.ve_out !== 1'b0 || bus.valid_out !== 1'b0) begin
                    errors++;
                    $display("FAIL aligned_last_token: got ve=%b valid=%b expected ve=0 valid=0", bus.ve_out, bus.valid_out);
                end
            end
            if (i == 19) begin
                checks++;
                if (bus.data_out !== 8'h01 || bus.ve_out !== 1'b1 || bus.control_out !== 2'd0 || bus.valid_out !== 1'b1) begin
                    errors++;
                    $display("FAIL aligned_decode: got data=%h ve=%b ctrl=%h valid=%b expected data=01 ve=1 ctrl=0 valid=1",
                             bus.data_out, bus.ve_out, bus.control_out, bus.valid_out);
                end
            end
        end
    endtask

    task automatic test_misaligned;
        logic       bits [$];
        logic [9:0] w;
        int         lock_at, found;
        lock_at = -1;
        found   = 0;
        repeat (3) bits.push_back(1'b0);
        for (int k = 0; k < 150; k++) begin
            w = (k == 130) ? 10'h1FF : 10'h354;
            for (int b = 0; b < 10; b++) bits.push_back(w[b]);
        end
        do_reset();
        for (int m = 0; m < 150; m++) begin
            for (int b = 0; b < 10; b++) w[b] = bits[10 * m + b];
            tick(w);
            if (lock_at < 0 && bus.locked_out === 1'b1) begin
                lock_at = m;
                checks++;
                if (dut.offset !== 4'd3) begin
                    errors++;
                    $display("FAIL misaligned_offset: got offset=%0d expected 3", dut.offset);
                end
            end
            if (!found && lock_at >= 0 && bus.valid_out === 1'b1 && bus.ve_out === 1'b1) begin
                found = 1;
                checks++;
                if (bus.data_out !== 8'h01) begin
                    errors++;
                    $display("FAIL misaligned_decode: got data=%h expected 01", bus.data_out);
                end
            end
        end
        checks++;
        if (lock_at < 0 || lock_at > 3 * 32 + 16 + 4) begin
            errors++;
            $display("FAIL misaligned_lock_time: got lock at word %0d expected 0..%0d", lock_at, 3 * 32 + 16 + 4);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL misaligned_data_seen: got no valid data word expected one with data 01");
        end
    endtask

    task automatic test_verify_abort;
        do_reset();
        for (int i = 0; i < 25; i++) begin
            tick(i == 5 ? 10'h1FF : 10'h354);
            if (i == 6) begin
                checks++;
                if (bus.locked_out !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_no_lock: got locked=%b expected 0", bus.locked_out);
                end
            end
            if (i == 7) begin
                checks++;
                if (dut.state !== SEARCH) begin
                    errors++;
                    $display("FAIL abort_to_search: got state=%0d expected %0d", dut.state, SEARCH);
                end
            end
            if (i == 22 || i == 23) begin
                checks++;
                if (bus.locked_out !== (i == 23)) begin
                    errors++;
                    $display("FAIL abort_relock: iter %0d got locked=%b expected %b", i, bus.locked_out, i == 23);
                end
            end
            if (i == 23) begin
                checks++;
                if (dut.offset !== 4'd0) begin
                    errors++;
                    $display("FAIL abort_offset: got offset=%0d expected 0", dut.offset);
                end
            end
        end
    endtask

    task automatic test_lock_loss;
        do_reset();
        for (int i = 0; i < 86; i++) begin
            tick(i < 16 ? 10'h354 : 10'h1FF);
            if (i == 17 || i == 80 || i == 81) begin
                checks++;
                if (bus.locked_out !== (i != 81)) begin
                    errors++;
                    $display("FAIL loss_locked: iter %0d got locked=%b expected %b", i, bus.locked_out, i != 81);
                end
            end
            if (i == 50 || i == 84) begin
                checks++;
                if (bus.valid_out !== (i == 50)) begin
                    errors++;
                    $display("FAIL loss_valid: iter %0d got valid=%b expected %b", i, bus.valid_out, i == 50);
                end
            end
            if (i == 81) begin
                checks++;
                if (dut.state !== SEARCH || dut.offset !== 4'd1) begin
                    errors++;
                    $display("FAIL loss_state: got state=%0d offset=%0d expected state=%0d offset=1", dut.state, dut.offset, SEARCH);
                end
            end
        end
    endtask

    task automatic test_err_flag;
        do_reset();
        for (int i = 0; i < 23; i++) begin
            tick(i == 16 ? 10'h2AA : 10'h354);
            if (i >= 18 && i <= 20) begin
                checks++;
                if (bus.err_out !== (ERR_EN && i == 19)) begin
                    errors++;
                    $display("FAIL err_flag: iter %0d got err=%b expected %b", i, bus.err_out, ERR_EN && i == 19);
                end
            end
            if (i == 19) begin
                checks++;
                if (bus.ve_out !== 1'b1 || bus.data_out !== 8'h01) begin
                    errors++;
                    $display("FAIL err_word_decode: got ve=%b data=%h expected ve=1 data=01", bus.ve_out, bus.data_out);
                end
            end
        end
    endtask

    task automatic test_random_decode;
        exp_t       exp_a [400];
        logic [9:0] w;
        logic [1:0] last_ctrl;
        int         since_tok, v, n;
        last_ctrl = 2'd0;
        since_tok = 0;
        n = 16 + 300 + 3;
        do_reset();
        for (int i = 0; i < n; i++) begin
            if (i < 16 || i >= 316) begin
                w = 10'h354;
            end else if (since_tok >= 20 || $urandom_range(3) == 0) begin
                w = tok_word(int'($urandom_range(3)));
            end else begin
                w = 10'($urandom);
                while (tok_val(w) >= 0) w = 10'($urandom);
            end
            v = tok_val(w);
            since_tok = (v >= 0) ? 0 : since_tok + 1;
            if (v >= 0) last_ctrl = 2'(v);
            exp_a[i].data = (v >= 0) ? 8'h00 : ref_decode(w);
            exp_a[i].ctrl = last_ctrl;
            exp_a[i].ve   = v < 0;
            exp_a[i].err  = ERR_EN && v < 0 && ref_trans(w) >= 7;
            tick(w);
            if (i >= 19) begin
                checks++;
                if (bus.data_out !== exp_a[i-3].data || bus.ve_out !== exp_a[i-3].ve ||
                    bus.control_out !== exp_a[i-3].ctrl || bus.valid_out !== 1'b1 || bus.err_out !== exp_a[i-3].err) begin
                    errors++;
                    $display("FAIL random_decode: word %0d got data=%h ve=%b ctrl=%h valid=%b err=%b expected data=%h ve=%b ctrl=%h valid=1 err=%b",
                             i - 3, bus.data_out, bus.ve_out, bus.control_out, bus.valid_out, bus.err_out,
                             exp_a[i-3].data, exp_a[i-3].ve, exp_a[i-3].ctrl, exp_a[i-3].err);
                end
            end
        end
    endtask

    initial begin
        bus.tmds_in = 10'h000;
        test_reset();
        test_aligned_lock();
        test_misaligned();
        test_verify_abort();
        test_lock_loss();
        test_err_flag();
        test_random_decode();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
